// File: rtl/hemaia_reset_requester.sv
// -----------------------------------------------------------------------------
// hemaia_reset_requester
//
// Issuing side of the per-channel reset path. A request carries a channel mask
// and a hold length and arrives over a valid/ready handshake. The block then:
//   1. Pulls the selected asynchronous local reset request lines low.
//   2. Waits until the reset controller reports those channels in reset. The
//      controller's synchronized reset state is fed back here and
//      re-synchronized.
//   3. Holds the lines low for the requested number of cycles.
//   4. Releases the lines and waits for the channels to leave reset.
// Completion is flagged with a one-cycle done pulse. If either wait exceeds
// the timeout, the request is aborted and the failing channels are reported.
// The block lives on the always-on clock. Resetting it only releases its own
// request lines; it never pulses a reset onto any other channel.
//
// Parameters
//   NumReset        number of reset channels (matches the reset controller)
//   MinPulseCycles  shortest hold once reset entry is confirmed
//   TimeoutCycles   cycle budget for each of the entry and exit waits
//   LenWidth        width of the requested hold length
//
// Ports
//   clk_i         always-on block clock
//   rst_ni        synchronous active-low reset
//   req_valid_i   request valid
//   req_ready_o   request ready, high only while idle
//   req_mask_i    channels to reset, bit i = channel i
//   req_len_i     requested hold length in clk_i cycles
//   local_rst_no  registered active-low reset requests to the controller
//   rst_state_i   controller reset state per channel (active low, async)
//   busy_o        high while a request is in progress
//   done_o        one-cycle completion pulse
//   err_o         timeout flag, valid with done_o, held until next accept
//   err_mask_o    channels that missed the awaited condition, held likewise
// -----------------------------------------------------------------------------
module hemaia_reset_requester #(
   parameter int unsigned NumReset       = 4,
   parameter int unsigned MinPulseCycles = 8,
   parameter int unsigned TimeoutCycles  = 1024,
   parameter int unsigned LenWidth       = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [NumReset-1:0] req_mask_i,
   input  logic [LenWidth-1:0] req_len_i,
   output logic [NumReset-1:0] local_rst_no,
   input  logic [NumReset-1:0] rst_state_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [NumReset-1:0] err_mask_o
);

   localparam int unsigned TcntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TcntWidth-1:0] TcntLast = TcntWidth'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      HOLD,
      EXIT,
      DONE
   } state_e;

   state_e              state_q, state_d;

   logic [NumReset-1:0] fb_p0, fb_p1;
   logic [NumReset-1:0] fb;

   logic [NumReset-1:0] mask_q, mask_d;
   logic [LenWidth-1:0] len_q, len_d;
   logic [LenWidth-1:0] hcnt_q, hcnt_d;
   logic [TcntWidth-1:0] tcnt_q, tcnt_d;
   logic [NumReset-1:0] local_rst_q, local_rst_d;
   logic                err_q, err_d;
   logic [NumReset-1:0] err_mask_q, err_mask_d;

   logic                fb_all_in_rst;
   logic                fb_all_out_rst;
   logic                tcnt_last;
   logic                hcnt_last;

   // Raise the requested length to the minimum pulse and saturate at the
   // field width. A floor of one cycle keeps the hold terminal count
   // reachable even if MinPulseCycles is configured as zero.
   function automatic logic [LenWidth-1:0] clamp_len(input logic [LenWidth-1:0] len);
      logic [63:0] len_v;
      logic [63:0] floor_v;
      logic [63:0] max_v;
      floor_v = (MinPulseCycles > 0) ? 64'(MinPulseCycles) : 64'd1;
      max_v   = (64'd1 << LenWidth) - 64'd1;
      len_v   = 64'(len);
      if (len_v < floor_v) len_v = floor_v;
      if (len_v > max_v)   len_v = max_v;
      return len_v[LenWidth-1:0];
   endfunction

   // ---- feedback synchronizer: rst_state_i -> fb_p0 -> fb_p1 ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fb_p0 <= '0;
         fb_p1 <= '0;
      end else begin
         fb_p0 <= rst_state_i;
         fb_p1 <= fb_p0;
      end
   end

   assign fb = fb_p1;

   // Only the selected channels take part in the entry/exit decisions.
   assign fb_all_in_rst  = ((fb & mask_q) == '0);
   assign fb_all_out_rst = ((fb & mask_q) == mask_q);
   assign tcnt_last      = (tcnt_q == TcntLast);
   assign hcnt_last      = (hcnt_q == (len_q - LenWidth'(1)));

   // ---- next-state and registered-output logic ----
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      len_d       = len_q;
      hcnt_d      = hcnt_q;
      tcnt_d      = tcnt_q;
      local_rst_d = local_rst_q;
      err_d       = err_q;
      err_mask_d  = err_mask_q;

      unique case (state_q)
         IDLE: begin
            // req_ready_o is high throughout IDLE, so valid alone is an accept.
            if (req_valid_i) begin
               mask_d     = req_mask_i;
               len_d      = clamp_len(req_len_i);
               err_d      = 1'b0;
               err_mask_d = '0;
               tcnt_d     = '0;
               hcnt_d     = '0;
               if (req_mask_i != '0) begin
                  state_d     = ENTER;
                  local_rst_d = ~req_mask_i;
               end else begin
                  state_d = DONE;
               end
            end
         end

         ENTER: begin
            // Reaching the condition on the terminal cycle still counts as success.
            if (fb_all_in_rst) begin
               state_d = HOLD;
               tcnt_d  = '0;
               hcnt_d  = '0;
            end else if (tcnt_last) begin
               state_d     = DONE;
               err_d       = 1'b1;
               err_mask_d  = fb & mask_q;
               local_rst_d = '1;
               tcnt_d      = '0;
            end else begin
               tcnt_d = tcnt_q + TcntWidth'(1);
            end
         end

         HOLD: begin
            // Lines rise on the same edge that enters EXIT, so the low
            // interval after entry confirmation is exactly len_q cycles.
            if (hcnt_last) begin
               state_d     = EXIT;
               local_rst_d = '1;
               hcnt_d      = '0;
               tcnt_d      = '0;
            end else begin
               hcnt_d = hcnt_q + LenWidth'(1);
            end
         end

         EXIT: begin
            if (fb_all_out_rst) begin
               state_d = DONE;
               tcnt_d  = '0;
            end else if (tcnt_last) begin
               state_d    = DONE;
               err_d      = 1'b1;
               err_mask_d = ~fb & mask_q;
               tcnt_d     = '0;
            end else begin
               tcnt_d = tcnt_q + TcntWidth'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d     = IDLE;
            local_rst_d = '1;
         end
      endcase
   end

   // ---- control registers ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         local_rst_q <= '1;
         err_q       <= 1'b0;
         err_mask_q  <= '0;
         tcnt_q      <= '0;
         hcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         local_rst_q <= local_rst_d;
         err_q       <= err_d;
         err_mask_q  <= err_mask_d;
         tcnt_q      <= tcnt_d;
         hcnt_q      <= hcnt_d;
      end
   end

   // ---- request data registers ----
   // These are only read after an accept has loaded them, so they need no reset.
   always_ff @(posedge clk_i) begin
      mask_q <= mask_d;
      len_q  <= len_d;
   end

   assign req_ready_o  = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign local_rst_no = local_rst_q;
   assign err_o        = err_q;
   assign err_mask_o   = err_mask_q;

endmodule

// File: tb/tb_hemaia_reset_requester.sv
module tb_hemaia_reset_requester;

   localparam int NR   = 4;
   localparam int MINP = 8;
   localparam int TMO  = 16;
   localparam int LW   = 16;
   localparam int HD   = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [NR-1:0] req_mask_i = '0;
   logic [LW-1:0] req_len_i = '0;
   logic [NR-1:0] local_rst_no;
   logic [NR-1:0] rst_state_i = '1;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [NR-1:0] err_mask_o;

   int checks = 0;
   int errors = 0;

   hemaia_reset_requester #(
      .NumReset      (NR),
      .MinPulseCycles(MINP),
      .TimeoutCycles (TMO),
      .LenWidth      (LW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_mask_i  (req_mask_i),
      .req_len_i   (req_len_i),
      .local_rst_no(local_rst_no),
      .rst_state_i (rst_state_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .err_mask_o  (err_mask_o)
   );

   always #5 clk_i = ~clk_i;

   // Reset controller model: each channel's reset state follows its request
   // line after lc cycles. s1 channels never enter reset; s0 channels, once
   // they have entered reset, never leave it.
   logic [NR-1:0] hist [HD];
   logic [NR-1:0] s1 = '0;
   logic [NR-1:0] s0 = '0;
   logic [NR-1:0] lat = '0;
   int            lc = 1;

   initial for (int i = 0; i < HD; i++) hist[i] = '1;

   always @(negedge clk_i) begin
      for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = local_rst_no;
      lat = (lat | ~hist[lc-1]) & s0;
      rst_state_i = (hist[lc-1] | s1) & ~lat;
   end

   typedef struct {
      logic [NR-1:0] mask;
      logic [LW-1:0] len;
      int            lcy;
      logic [NR-1:0] f1;
      logic [NR-1:0] f0;
      bit            holdv;
      int            e_low;
      int            e_done;
      bit            e_err;
      logic [NR-1:0] e_em;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level expectation: low-cycle count, cycle index of done_o
   // counted from the accept edge, and the error report.
   task automatic predict(input logic [NR-1:0] m, input logic [LW-1:0] len, input int l,
                          input logic [NR-1:0] f1, input logic [NR-1:0] f0,
                          output int e_low, output int e_done, output bit e_err,
                          output logic [NR-1:0] e_em);
      int lq;
      int wait_c;
      lq     = (int'(len) < MINP) ? MINP : int'(len);
      wait_c = l + 2;   // controller latency plus two synchronizer stages
      if (m == '0) begin
         e_low = 0; e_done = 1; e_err = 0; e_em = '0;
      end else if (((f1 & m) != '0) || (wait_c > TMO)) begin
         e_low = TMO; e_done = TMO + 1; e_err = 1;
         e_em  = (wait_c > TMO) ? m : (f1 & m);
      end else if ((f0 & m) != '0) begin
         e_low = wait_c + lq; e_done = e_low + TMO + 1; e_err = 1; e_em = f0 & m;
      end else begin
         e_low = wait_c + lq; e_done = e_low + wait_c + 1; e_err = 0; e_em = '0;
      end
   endtask

   task automatic idle(input int n);
      int extra;
      extra = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); @(negedge clk_i);
         if (done_o || !req_ready_o) extra++;
      end
      chk("idle no activity", extra, 0);
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      int low, last_low, shape_bad, ready_bad, done_idx;
      bit de;
      logic [NR-1:0] dm;
      low = 0; last_low = 0; shape_bad = 0; ready_bad = 0; done_idx = 0;
      de = 0; dm = '0;
      lc = v.lcy; s1 = v.f1; s0 = v.f0;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_mask_i = v.mask; req_len_i = v.len;
      for (int k = 1; k <= 200 && done_idx == 0; k++) begin
         @(posedge clk_i); @(negedge clk_i);
         if (!v.holdv) req_valid_i = 1'b0;
         if (k == 1) chk({tag, " err cleared"}, {27'd0, err_o, err_mask_o}, 32'd0);
         if (local_rst_no != '1) begin
            low++;
            last_low = k;
            if (local_rst_no != ~v.mask) shape_bad++;
         end
         if (req_ready_o || !busy_o) ready_bad++;
         if (done_o) begin
            done_idx = k; de = err_o; dm = err_mask_o;
            req_valid_i = 1'b0;
         end
      end
      chk({tag, " done cycle"}, done_idx, v.e_done);
      chk({tag, " low cycles"}, low, v.e_low);
      chk({tag, " low contiguous"}, last_low, v.e_low);
      chk({tag, " line shape"}, shape_bad, 0);
      chk({tag, " ready low while busy"}, ready_bad, 0);
      chk({tag, " err_o"}, de, v.e_err);
      chk({tag, " err_mask_o"}, dm, v.e_em);
      @(posedge clk_i); @(negedge clk_i);
      chk({tag, " single done pulse"}, done_o, 1'b0);
      chk({tag, " ready after done"}, {req_ready_o, busy_o}, 2'b10);
      chk({tag, " err held"}, {27'd0, err_o, err_mask_o}, {27'd0, v.e_err, v.e_em});
      chk({tag, " lines released"}, local_rst_no, 4'hF);
      s1 = '0; s0 = '0;
      idle(24);
   endtask

   initial begin
      int   dc;
      vec_t rv;

      tbl[0] = '{4'b0010, 16'd20,  3, 4'b0000, 4'b0000, 1'b0, 25, 31, 1'b0, 4'b0000};
      tbl[1] = '{4'b1111, 16'd2,   1, 4'b0000, 4'b0000, 1'b0, 11, 15, 1'b0, 4'b0000};
      tbl[2] = '{4'b0101, 16'd20,  2, 4'b0100, 4'b0000, 1'b0, 16, 17, 1'b1, 4'b0100};
      tbl[3] = '{4'b0001, 16'd10,  2, 4'b0000, 4'b0001, 1'b0, 14, 31, 1'b1, 4'b0001};
      tbl[4] = '{4'b0000, 16'd5,   1, 4'b0000, 4'b0000, 1'b0,  0,  1, 1'b0, 4'b0000};
      tbl[5] = '{4'b1000, 16'd9,   4, 4'b0000, 4'b0000, 1'b1, 15, 22, 1'b0, 4'b0000};
      tbl[6] = '{4'b0110, 16'd8,   2, 4'b1000, 4'b0001, 1'b0, 12, 17, 1'b0, 4'b0000};
      tbl[7] = '{4'b1010, 16'd3,  14, 4'b0000, 4'b0000, 1'b0, 24, 41, 1'b0, 4'b0000};
      tbl[8] = '{4'b0011, 16'd8,  15, 4'b0000, 4'b0000, 1'b0, 16, 17, 1'b1, 4'b0011};

      // Reset held for three edges, then released.
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      chk("reset lines", local_rst_no, 4'hF);
      chk("reset ready/busy", {req_ready_o, busy_o}, 2'b10);
      chk("reset done", done_o, 1'b0);
      chk("reset err", {27'd0, err_o, err_mask_o}, 32'd0);
      idle(24);

      for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

      // Reset applied during HOLD drops the request without a done pulse.
      lc = 1;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_mask_i = 4'b1111; req_len_i = 16'd30;
      @(posedge clk_i); @(negedge clk_i);
      req_valid_i = 1'b0;
      repeat (9) begin @(posedge clk_i); @(negedge clk_i); end
      chk("hold lines low before reset", local_rst_no, 4'h0);
      rst_ni = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      rst_ni = 1'b1;
      chk("mid reset lines", local_rst_no, 4'hF);
      chk("mid reset ready/busy", {req_ready_o, busy_o}, 2'b10);
      chk("mid reset done", done_o, 1'b0);
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); @(negedge clk_i);
         if (done_o || local_rst_no != '1) dc++;
      end
      chk("mid reset request dropped", dc, 0);

      // Randomized requests checked against the transaction-level model.
      for (int i = 0; i < 20; i++) begin
         rv.mask  = 4'($urandom_range(0, 15));
         rv.len   = 16'($urandom_range(0, 40));
         rv.lcy   = $urandom_range(1, 4);
         rv.f1    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         rv.f0    = ($urandom_range(0, 3) == 0) ? (4'($urandom) & ~rv.f1) : 4'b0000;
         rv.holdv = 1'($urandom_range(0, 1));
         predict(rv.mask, rv.len, rv.lcy, rv.f1, rv.f0, rv.e_low, rv.e_done, rv.e_err, rv.e_em);
         run_txn($sformatf("rnd%0d", i), rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
